// File: rtl/wb2axilwr_if.sv
// Pipelined Wishbone write slave and AXI-lite write master signals, grouped for the bridge.
// The slave modport is the bridge's view; the master modport is the WB master and AXI slave side.
interface wb2axilwr_if #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 28
);
   localparam int DW = C_AXI_DATA_WIDTH;
   localparam int AW = C_AXI_ADDR_WIDTH - $clog2(DW/8);

   logic                        i_wb_cyc;
   logic                        i_wb_stb;
   logic                        i_wb_we;
   logic [AW-1:0]               i_wb_addr;
   logic [DW-1:0]               i_wb_data;
   logic [DW/8-1:0]             i_wb_sel;
   logic                        o_wb_stall;
   logic                        o_wb_ack;
   logic                        o_wb_err;

   logic                        o_axi_awvalid;
   logic                        i_axi_awready;
   logic [C_AXI_ADDR_WIDTH-1:0] o_axi_awaddr;
   logic [2:0]                  o_axi_awprot;
   logic                        o_axi_wvalid;
   logic                        i_axi_wready;
   logic [DW-1:0]               o_axi_wdata;
   logic [DW/8-1:0]             o_axi_wstrb;
   logic                        i_axi_bvalid;
   logic                        o_axi_bready;
   logic [1:0]                  i_axi_bresp;

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      output o_wb_stall, o_wb_ack, o_wb_err,
      output o_axi_awvalid, o_axi_awaddr, o_axi_awprot,
      input  i_axi_awready,
      output o_axi_wvalid, o_axi_wdata, o_axi_wstrb,
      input  i_axi_wready,
      input  i_axi_bvalid, i_axi_bresp,
      output o_axi_bready
   );

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      input  o_wb_stall, o_wb_ack, o_wb_err,
      input  o_axi_awvalid, o_axi_awaddr, o_axi_awprot,
      output i_axi_awready,
      input  o_axi_wvalid, o_axi_wdata, o_axi_wstrb,
      output i_axi_wready,
      output i_axi_bvalid, i_axi_bresp,
      input  o_axi_bready
   );
endinterface

// File: rtl/wb2axilwr.sv
// Wishbone pipelined write -> AXI-lite write bridge; AW/W issue 1 cycle after accept, ack/err 1 cycle after B.
// Stalls on AW/W backpressure, full outstanding window, drain, or a read that cannot be refused yet.
module wb2axilwr #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 28,
   parameter int LGFIFO           = 3
) (
   input  logic           i_clk,
   input  logic           w_reset,
   wb2axilwr_if.slave     bus
);
   localparam int DW  = C_AXI_DATA_WIDTH;
   localparam int LSB = $clog2(DW/8);
   localparam logic [LGFIFO:0] FULL = {1'b1, {LGFIFO{1'b0}}};

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

   state_t          state;
   logic [LGFIFO:0] outstanding;
   logic [LGFIFO:0] outstanding_nxt;
   logic            read_err_pending;
   logic            rd_blocked;
   logic            wr_accept;
   logic            rd_accept;
   logic            b_fire;
   logic            b_err;
   logic            drain_trig;
   logic            drain_needed;
   logic            unused;

   assign unused = bus.i_axi_bresp[0];

   assign bus.o_axi_awprot = 3'b000;
   assign bus.o_axi_bready = !w_reset;

   // Reads are answered with an error, but only once every earlier write has retired.
   assign rd_blocked = bus.i_wb_stb && !bus.i_wb_we
                    && (outstanding != '0 || bus.o_axi_awvalid || bus.o_axi_wvalid);

   assign bus.o_wb_stall = (bus.o_axi_awvalid && !bus.i_axi_awready)
                        || (bus.o_axi_wvalid && !bus.i_axi_wready)
                        || (outstanding == FULL)
                        || (state == DRAIN)
                        || read_err_pending
                        || rd_blocked;

   assign wr_accept = bus.i_wb_cyc && bus.i_wb_stb && !bus.o_wb_stall && bus.i_wb_we;
   assign rd_accept = bus.i_wb_cyc && bus.i_wb_stb && !bus.o_wb_stall && !bus.i_wb_we;
   // A stray response with nothing in flight is dropped entirely.
   assign b_fire    = bus.i_axi_bvalid && bus.o_axi_bready && (outstanding != '0);
   assign b_err     = bus.i_axi_bresp[1];

   assign drain_trig   = !bus.i_wb_cyc || (b_fire && b_err);
   assign drain_needed = (outstanding > {{LGFIFO{1'b0}}, b_fire})
                      || bus.o_axi_awvalid || bus.o_axi_wvalid || wr_accept;

   always_comb begin
      outstanding_nxt = outstanding;
      if (wr_accept && !b_fire)
         outstanding_nxt = outstanding + 1'b1;
      else if (!wr_accept && b_fire)
         outstanding_nxt = outstanding - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (w_reset) begin
         state             <= IDLE;
         outstanding       <= '0;
         read_err_pending  <= 1'b0;
         bus.o_axi_awvalid <= 1'b0;
         bus.o_axi_wvalid  <= 1'b0;
         bus.o_wb_ack      <= 1'b0;
         bus.o_wb_err      <= 1'b0;
      end else begin
         outstanding      <= outstanding_nxt;
         read_err_pending <= rd_accept;
         bus.o_wb_ack     <= (state == ACTIVE) && b_fire && !b_err && bus.i_wb_cyc;
         bus.o_wb_err     <= rd_accept
                          || ((state == ACTIVE) && b_fire && b_err && bus.i_wb_cyc);

         if (wr_accept) begin
            bus.o_axi_awvalid <= 1'b1;
            bus.o_axi_wvalid  <= 1'b1;
         end else begin
            if (bus.i_axi_awready)
               bus.o_axi_awvalid <= 1'b0;
            if (bus.i_axi_wready)
               bus.o_axi_wvalid <= 1'b0;
         end

         case (state)
            IDLE:
               if (wr_accept)
                  state <= ACTIVE;
            ACTIVE:
               if (drain_trig && drain_needed)
                  state <= DRAIN;
               else if (outstanding_nxt == '0)
                  state <= IDLE;
            DRAIN:
               if (outstanding == '0 && !bus.o_axi_awvalid && !bus.o_axi_wvalid)
                  state <= IDLE;
            default:
               state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_accept) begin
         bus.o_axi_awaddr <= {bus.i_wb_addr, {LSB{1'b0}}};
         bus.o_axi_wdata  <= bus.i_wb_data;
         bus.o_axi_wstrb  <= bus.i_wb_sel;
      end
   end
endmodule
